// File: rtl/debounce_scheduler.sv
// Debounces NUM_IN inputs with one shared settle counter. A round-robin
// scheduler grants the counter to one changed input and commits or abandons it.
module debounce_scheduler #(
  parameter int NUM_IN  = 4,
  parameter int CNT_W   = 6,
  parameter int CNT_MAX = 63,
  localparam int GW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] sig_in,
  input  logic              tick,
  output logic [NUM_IN-1:0] db_out,
  output logic [NUM_IN-1:0] db_pulse,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] s1_q, s2_q;
  logic [NUM_IN-1:0] db_q, db_d;
  logic [NUM_IN-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cand_q, cand_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [NUM_IN-1:0] pending;
  logic [GW-1:0]     sel;
  logic              found;
  logic [GW-1:0]     next_rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= IDLE;
      db_q    <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
      cand_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      db_q    <= db_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // First pending input at or after rr_q, wrapping modulo NUM_IN.
  always_comb begin
    pending = s2_q ^ db_q;
    sel     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && pending[(int'(rr_q) + k) % NUM_IN]) begin
        found = 1'b1;
        sel   = GW'((int'(rr_q) + k) % NUM_IN);
      end
    end
    next_rr = (grant_q == GW'(NUM_IN - 1)) ? '0 : grant_q + GW'(1);
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    pulse_d = '0;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          cand_d  = s2_q[sel];
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A bounce back to the old value wins over reaching terminal count.
        if (s2_q[grant_q] != cand_q) begin
          rr_d    = next_rr;
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == CNT_W'(CNT_MAX)) state_d = COMMIT;
          else                          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        db_d[grant_q]    = cand_q;
        pulse_d[grant_q] = 1'b1;
        rr_d             = next_rr;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign db_out   = db_q;
  assign db_pulse = pulse_q;
  assign busy     = (state_q == COUNT) || (state_q == COMMIT);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler: stimulus pushes expected commits,
// a monitor pops and checks them whenever db_pulse fires.
module tb_debounce_scheduler;

  localparam int NUM_IN  = 4;
  localparam int CNT_MAX = 63;
  localparam int LAT     = CNT_MAX + 5;
  localparam int GAP     = CNT_MAX + 3;

  typedef struct {
    logic [3:0] pulse;
    logic [3:0] db;
    int         at_edge;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] sig_in;
  logic       tick;
  logic [3:0] db_out;
  logic [3:0] db_pulse;
  logic       busy;
  logic [1:0] grant_id;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   tick_mode;
  exp_t q[$];

  debounce_scheduler #(.NUM_IN(NUM_IN), .CNT_W(6), .CNT_MAX(CNT_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .tick     (tick),
    .db_out   (db_out),
    .db_pulse (db_pulse),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // tick=1 on every edge e with e%4==0 when gated, else always high.
  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tick = tick_mode ? ((cyc % 4) == 3) : 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] d, input int e);
    exp_t x;
    x.pulse = p;
    x.db = d;
    x.at_edge = e;
    q.push_back(x);
  endtask

  // Monitor: any non-zero db_pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && db_pulse != 4'b0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got pulse %b db_out %b expected none (cycle %0d)",
                 db_pulse, db_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse", int'(db_pulse), int'(e.pulse));
        chk("db_out", int'(db_out), int'(e.db));
        chk("pulse_edge", cyc, e.at_edge);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_db_out"}, int'(db_out), 0);
    chk({tag, "_db_pulse"}, int'(db_pulse), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_grant_id"}, int'(grant_id), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sig_in = 4'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    int e;
    reset = 1'b1;
    sig_in = 4'b0;
    tick_mode = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("por");
    reset = 1'b0;

    // Single clean press and release of bit 0.
    @(negedge clk);
    n = cyc;
    sig_in = 4'b0001;
    push(4'b0001, 4'b0001, n + LAT);
    wait_until(n + 2);  chk("busy_e2", int'(busy), 0);
    wait_until(n + 3);  chk("busy_e3", int'(busy), 1);
    wait_until(n + 67); chk("busy_e67", int'(busy), 1);
    wait_until(n + 68); chk("busy_e68", int'(busy), 0);
    drain(100);
    @(negedge clk);
    n = cyc;
    sig_in = 4'b0000;
    push(4'b0001, 4'b0000, n + LAT);
    drain(120);

    // Bounce on bit 2: granted, then abandoned without a pulse; rr_ptr -> 3.
    @(negedge clk);
    n = cyc;
    sig_in = 4'b0100;
    wait_until(n + 10);
    chk("bounce_grant", int'(grant_id), 2);
    chk("bounce_busy", int'(busy), 1);
    wait_until(n + 20);
    sig_in = 4'b0000;
    wait_until(n + 30);
    chk("abandon_busy", int'(busy), 0);
    chk("abandon_db_out", int'(db_out), 0);
    chk("abandon_grant_hold", int'(grant_id), 2);

    // Contention with rr_ptr=3: bit3, then bit0, then bit1.
    @(negedge clk);
    n = cyc;
    sig_in = 4'b1011;
    push(4'b1000, 4'b1000, n + LAT);
    push(4'b0001, 4'b1001, n + LAT + GAP);
    push(4'b0010, 4'b1011, n + LAT + 2 * GAP);
    drain(300);

    // Reset mid-COUNT at cnt=30; bit 0 held high is re-debounced afterwards.
    do_reset();
    @(negedge clk);
    n = cyc;
    sig_in = 4'b0001;
    wait_until(n + 33);
    reset = 1'b1;
    @(negedge clk);
    r = cyc;
    chk_idle_outputs("midreset");
    reset = 1'b0;
    push(4'b0001, 4'b0001, r + LAT);
    drain(120);

    // Contention from reset (rr_ptr=0): bit0, bit1, bit3.
    do_reset();
    @(negedge clk);
    n = cyc;
    sig_in = 4'b1011;
    push(4'b0001, 4'b0001, n + LAT);
    push(4'b0010, 4'b0011, n + LAT + GAP);
    push(4'b1000, 4'b1011, n + LAT + 2 * GAP);
    drain(300);

    // Fairness: bit1 commits (rr_ptr=2), then bits 0 and 3 together -> bit3 first.
    do_reset();
    @(negedge clk);
    n = cyc;
    sig_in = 4'b0010;
    push(4'b0010, 4'b0010, n + LAT);
    drain(120);
    @(negedge clk);
    n = cyc;
    sig_in = 4'b1011;
    push(4'b1000, 4'b1010, n + LAT);
    push(4'b0001, 4'b1011, n + LAT + GAP);
    drain(200);

    // tick every 4th cycle: 64 counting ticks after entering COUNT, then COMMIT.
    do_reset();
    tick_mode = 1'b1;
    repeat (2) @(negedge clk);
    n = cyc;
    sig_in = 4'b0001;
    e = n + 4;
    while ((e % 4) != 0) e++;
    push(4'b0001, 4'b0001, e + CNT_MAX * 4 + 1);
    wait_until(n + LAT);
    chk("tick_busy_hold", int'(busy), 1);
    chk("tick_db_hold", int'(db_out), 0);
    drain(400);
    tick_mode = 1'b0;

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces NUM_IN mechanical inputs (buttons/switches) using one shared settle counter instead of one counter per input.
- Each input has a 2-flop synchronizer and a stable-value register.
- A round-robin scheduler grants the shared counter to one input whose synchronized value differs from its stable value, then commits or abandons the change.
- Sits between the board pins and the FSM/display logic; downstream blocks consume db_out and the db_pulse strobes.

Parameters:
- NUM_IN, 4, number of debounced inputs (2..8).
- CNT_W, 6, settle counter width.
- CNT_MAX, 63, terminal count; must satisfy CNT_MAX ≤ 2^CNT_W − 1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- sig_in, input, NUM_IN, raw asynchronous inputs.
- tick, input, 1, counter enable; the settle counter advances only on cycles with tick=1 (tie high for clk-rate counting).
- db_out, output, NUM_IN, debounced stable values.
- db_pulse, output, NUM_IN, one-cycle strobe on the bit whose db_out just changed.
- busy, output, 1, high while the scheduler is in COUNT or COMMIT.
- grant_id, output, clog2(NUM_IN), index currently granted; holds its last value while idle.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - sync flops, db_out, db_pulse, cnt, cand, grant_id and rr_ptr go to 0.
  - state goes to IDLE; busy=0.
  - Reset mid-COUNT abandons the candidate with no db_pulse.
  - Inputs held at 1 through reset are re-debounced normally afterwards.
- Synchronizer: s1 <= sig_in; s2 <= s1.
- pending[i] = (s2[i] != db_out[i]), combinational.
- IDLE:
  - If any pending bit is set, select the first pending index scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
  - Register grant_id <= sel, cand <= s2[sel], cnt <= 0, state <= COUNT.
  - If nothing is pending, remain in IDLE.
- COUNT:
  - If s2[grant_id] != cand (the input bounced back), abandon: state <= IDLE, rr_ptr <= grant_id+1 mod NUM_IN, no pulse, db_out unchanged. Abandon has priority over terminal count on the same cycle.
  - Else if tick=1 and cnt == CNT_MAX, state <= COMMIT.
  - Else if tick=1, cnt <= cnt+1.
  - With tick=0, cnt holds; the bounce check still runs every cycle.
- COMMIT (exactly one cycle):
  - db_out[grant_id] <= cand; db_pulse <= one-hot(grant_id).
  - rr_ptr <= grant_id+1 mod NUM_IN; state <= IDLE.
- db_pulse is registered and is 0 on every cycle except the cycle after COMMIT.
- Latency with tick=1 and the scheduler idle: sig_in changes before edge 1; db_out and db_pulse change at edge CNT_MAX+5 (edge 68 with defaults).
- Contention:
  - Inputs that change while another is granted stay pending and are served in round-robin order.
  - No input waits more than NUM_IN−1 grants.
  - Non-granted inputs that toggle and return before being granted never generate a grant.
- cnt never wraps: it saturates at CNT_MAX by construction.
- Simultaneous pending bits in IDLE with rr_ptr=0 → index 0 is served first, then 1, etc.
- Only one db_pulse bit is ever high in a cycle.

Test Plan:
- Single clean press: reset, then sig_in=4'b0001 held → db_out=4'b0001 and db_pulse=4'b0001 for exactly one cycle at edge 68; busy high edges 3–68.
- Bounce abandon: sig_in[2] high for 20 cycles then low → grant_id=2, then return to IDLE; no db_pulse; db_out stays 0; rr_ptr=3.
- Contention: sig_in goes from 0 to 4'b1011 simultaneously → commits in order bit0, bit1, bit3, each 66 cycles apart, with three single-bit pulses.
- Round-robin fairness: after bit1 commits (rr_ptr=2), bits 0 and 3 become pending together → bit3 is granted before bit0.
- tick gating: tick asserted every 4th cycle, single press → commit is delayed to about 4×(CNT_MAX+1) cycles; cnt holds on tick=0 cycles.
- Reset mid-operation: reset asserted at cnt=30 for 1 cycle with sig_in[0]=1 held → outputs 0; a fresh commit occurs 68 edges after reset deasserts.
